exc_commit_ctrl: RTL and testbench

//  WB-stage commit controller; the issuing side of the CSR unit's write/exception interface.
//  Per retiring instruction it does four things:
//  - prioritises pending exceptions and drives wb_ex/ecode/esubcode/pc or ertn_flush;
//  - forms the CSR write (csrwr / csrxchg mask merge);
//  - redirects Pre-IF to ex_entry/er_entry through a ready/valid handshake;
//  - holds a pipeline flush for FLUSH_CYCLES.

---
 rtl/exc_commit_ctrl_pkg.sv | 33 +++
 rtl/exc_prio_enc.sv | 21 ++
 rtl/exc_commit_ctrl.sv | 128 ++++++++++++
 tb/tb_exc_commit_ctrl.sv | 438 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/exc_commit_ctrl_pkg.sv
// Shared definitions for the WB-stage commit controller: exception codes, exc_vec bit positions,
// CSR op encodings and FSM states.
package exc_commit_ctrl_pkg;

  localparam logic [5:0] ECODE_INT  = 6'h00;
  localparam logic [5:0] ECODE_ADEF = 6'h08;
  localparam logic [5:0] ECODE_ALE  = 6'h09;
  localparam logic [5:0] ECODE_SYS  = 6'h0B;
  localparam logic [5:0] ECODE_BRK  = 6'h0C;
  localparam logic [5:0] ECODE_INE  = 6'h0D;

  // Bit positions inside wb_exc_vec = {ALE,BRK,SYS,INE,ADEF,INT}
  localparam int unsigned EXC_INT  = 0;
  localparam int unsigned EXC_ADEF = 1;
  localparam int unsigned EXC_INE  = 2;
  localparam int unsigned EXC_SYS  = 3;
  localparam int unsigned EXC_BRK  = 4;
  localparam int unsigned EXC_ALE  = 5;

  typedef enum logic [1:0] {
    CsrNone = 2'b00,
    CsrWr   = 2'b01,
    CsrXchg = 2'b10,
    CsrRsv  = 2'b11
  } csr_op_e;

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StRedir = 2'b01,
    StDrain = 2'b10
  } state_e;

endpackage

// File: rtl/exc_prio_enc.sv
// Fixed-priority exception encoder: INT > ADEF > INE > SYS > BRK > ALE.
module exc_prio_enc
  import exc_commit_ctrl_pkg::*;
(
  input  logic [5:0] exc_vec,
  output logic       any,
  output logic [5:0] ecode
);

  always_comb begin
    any   = |exc_vec;
    ecode = ECODE_INT;
    if (exc_vec[EXC_INT])       ecode = ECODE_INT;
    else if (exc_vec[EXC_ADEF]) ecode = ECODE_ADEF;
    else if (exc_vec[EXC_INE])  ecode = ECODE_INE;
    else if (exc_vec[EXC_SYS])  ecode = ECODE_SYS;
    else if (exc_vec[EXC_BRK])  ecode = ECODE_BRK;
    else if (exc_vec[EXC_ALE])  ecode = ECODE_ALE;
  end

endmodule

// File: rtl/exc_commit_ctrl.sv
// WB-stage commit controller: exception/ERTN commit, CSR write forming, Pre-IF redirect and flush.
// Optional EXC_BADV_EN adds the bad-virtual-address update port.
module exc_commit_ctrl
  import exc_commit_ctrl_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = 3,
  parameter int unsigned CNT_W        = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wb_valid,
  output logic        wb_ready,
  input  logic [31:0] wb_pc_in,
  input  logic [5:0]  wb_exc_vec,
  input  logic        wb_is_ertn,
  input  logic [1:0]  wb_csr_op,
  input  logic [13:0] wb_csr_num,
  input  logic [31:0] wb_rj_val,
  input  logic [31:0] wb_rd_val,
  input  logic [31:0] wb_csr_old,
  input  logic [31:0] ex_entry,
  input  logic [31:0] er_entry,
  output logic        csr_we,
  output logic [13:0] csr_wnum,
  output logic [31:0] csr_wdata,
  output logic        wb_ex,
  output logic [5:0]  wb_ecode,
  output logic [8:0]  wb_esubcode,
  output logic [31:0] wb_pc,
  output logic        ertn_flush,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  input  logic        redirect_ready,
  output logic        flush_o
`ifdef EXC_BADV_EN
  ,
  input  logic [31:0] wb_vaddr,
  output logic        wb_badv_we,
  output logic [31:0] wb_badv
`endif
);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       rpc_q, rpc_d;
  logic              exc_any;
  logic [5:0]        exc_code;
  csr_op_e           op;

  assign op = csr_op_e'(wb_csr_op);

  exc_prio_enc u_prio (
    .exc_vec (wb_exc_vec),
    .any     (exc_any),
    .ecode   (exc_code)
  );

  // Data outputs are unqualified; consumers gate them with the strobes.
  assign wb_ecode    = exc_code;
  assign wb_esubcode = '0;
  assign wb_pc       = wb_pc_in;
  assign csr_wnum    = wb_csr_num;
  assign csr_wdata   = (op == CsrWr) ? wb_rd_val
                                     : (wb_rd_val & wb_rj_val) | (wb_csr_old & ~wb_rj_val);
  assign redirect_pc = rpc_q;

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    rpc_d          = rpc_q;
    wb_ready       = 1'b0;
    wb_ex          = 1'b0;
    ertn_flush     = 1'b0;
    csr_we         = 1'b0;
    redirect_valid = 1'b0;
    flush_o        = 1'b0;
    unique case (state_q)
      StIdle: begin
        wb_ready = 1'b1;
        if (wb_valid) begin
          if (exc_any) begin
            wb_ex   = 1'b1;
            rpc_d   = ex_entry;
            state_d = StRedir;
          end else if (wb_is_ertn) begin
            ertn_flush = 1'b1;
            rpc_d      = er_entry;
            state_d    = StRedir;
          end else begin
            csr_we = (op == CsrWr) || (op == CsrXchg);
          end
        end
      end
      StRedir: begin
        redirect_valid = 1'b1;
        flush_o        = 1'b1;
        if (redirect_ready) begin
          cnt_d   = CNT_W'(FLUSH_CYCLES - 1);
          state_d = StDrain;
        end
      end
      StDrain: begin
        flush_o = 1'b1;
        if (cnt_q == '0) state_d = StIdle;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      default: state_d = StIdle;
    endcase
  end

`ifdef EXC_BADV_EN
  assign wb_badv_we = wb_ex && ((exc_code == ECODE_ADEF) || (exc_code == ECODE_ALE));
  assign wb_badv    = (exc_code == ECODE_ADEF) ? wb_pc_in : wb_vaddr;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      rpc_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rpc_q   <= rpc_d;
    end
  end

endmodule

// File: tb/tb_exc_commit_ctrl.sv
// Scoreboard bench for exc_commit_ctrl: expected commit results are queued when driven and
// popped at each accepted commit; FSM/redirect/flush timing is checked inline per scenario.
module tb_exc_commit_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        wb_valid = 1'b0;
  logic        wb_ready;
  logic [31:0] wb_pc_in = '0;
  logic [5:0]  wb_exc_vec = '0;
  logic        wb_is_ertn = 1'b0;
  logic [1:0]  wb_csr_op = '0;
  logic [13:0] wb_csr_num = '0;
  logic [31:0] wb_rj_val = '0;
  logic [31:0] wb_rd_val = '0;
  logic [31:0] wb_csr_old = '0;
  logic [31:0] ex_entry = '0;
  logic [31:0] er_entry = '0;
  logic        csr_we;
  logic [13:0] csr_wnum;
  logic [31:0] csr_wdata;
  logic        wb_ex;
  logic [5:0]  wb_ecode;
  logic [8:0]  wb_esubcode;
  logic [31:0] wb_pc;
  logic        ertn_flush;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        redirect_ready = 1'b0;
  logic        flush_o;
`ifdef EXC_BADV_EN
  logic [31:0] wb_vaddr = '0;
  logic        wb_badv_we;
  logic [31:0] wb_badv;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic        we;
    logic [13:0] wnum;
    logic [31:0] wdata;
    logic        ex;
    logic [5:0]  ecode;
    logic [31:0] pc;
    logic        ertn;
    logic        badv_we;
    logic [31:0] badv;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  always #5 clk = ~clk;

  exc_commit_ctrl #(
    .FLUSH_CYCLES (3),
    .CNT_W        (2)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .wb_valid       (wb_valid),
    .wb_ready       (wb_ready),
    .wb_pc_in       (wb_pc_in),
    .wb_exc_vec     (wb_exc_vec),
    .wb_is_ertn     (wb_is_ertn),
    .wb_csr_op      (wb_csr_op),
    .wb_csr_num     (wb_csr_num),
    .wb_rj_val      (wb_rj_val),
    .wb_rd_val      (wb_rd_val),
    .wb_csr_old     (wb_csr_old),
    .ex_entry       (ex_entry),
    .er_entry       (er_entry),
    .csr_we         (csr_we),
    .csr_wnum       (csr_wnum),
    .csr_wdata      (csr_wdata),
    .wb_ex          (wb_ex),
    .wb_ecode       (wb_ecode),
    .wb_esubcode    (wb_esubcode),
    .wb_pc          (wb_pc),
    .ertn_flush     (ertn_flush),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .redirect_ready (redirect_ready),
    .flush_o        (flush_o)
`ifdef EXC_BADV_EN
    ,
    .wb_vaddr       (wb_vaddr),
    .wb_badv_we     (wb_badv_we),
    .wb_badv        (wb_badv)
`endif
  );

  // Reference priority: INT > ADEF > INE > SYS > BRK > ALE (bit order {ALE,BRK,SYS,INE,ADEF,INT}).
  function automatic logic [5:0] model_ecode(input logic [5:0] v);
    if (v[0])      return 6'h00;
    else if (v[1]) return 6'h08;
    else if (v[2]) return 6'h0D;
    else if (v[3]) return 6'h0B;
    else if (v[4]) return 6'h0C;
    else           return 6'h09;
  endfunction

  function automatic void push_exp(input logic we, input logic [13:0] wnum,
                                   input logic [31:0] wdata, input logic ex,
                                   input logic [5:0] ecode, input logic [31:0] pc,
                                   input logic ertn, input logic badv_we,
                                   input logic [31:0] badv);
    exp_t e;
    e.we = we; e.wnum = wnum; e.wdata = wdata; e.ex = ex; e.ecode = ecode; e.pc = pc;
    e.ertn = ertn; e.badv_we = badv_we; e.badv = badv;
    sb.push_back(e);
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard consumer: every accepted commit pops one expectation; strobes elsewhere are errors.
  always @(negedge clk) begin
    if (!reset && wb_valid && wb_ready) begin
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL sb_empty: commit accepted with no expected entry (pc=%h)", wb_pc_in);
      end else begin
        mon_e = sb.pop_front();
        if ({csr_we, wb_ex, ertn_flush} !== {mon_e.we, mon_e.ex, mon_e.ertn}) begin
          n_fail++;
          $display("FAIL strobes: got we/ex/ertn=%b%b%b expected %b%b%b", csr_we, wb_ex,
                   ertn_flush, mon_e.we, mon_e.ex, mon_e.ertn);
        end
        if (mon_e.we) begin
          n_checks++;
          if (csr_wnum !== mon_e.wnum || csr_wdata !== mon_e.wdata) begin
            n_fail++;
            $display("FAIL csr_write: got num=%h data=%h expected num=%h data=%h", csr_wnum,
                     csr_wdata, mon_e.wnum, mon_e.wdata);
          end
        end
        if (mon_e.ex) begin
          n_checks++;
          if (wb_ecode !== mon_e.ecode || wb_pc !== mon_e.pc || wb_esubcode !== 9'd0) begin
            n_fail++;
            $display("FAIL exc_info: got ecode=%h pc=%h sub=%h expected ecode=%h pc=%h sub=0",
                     wb_ecode, wb_pc, wb_esubcode, mon_e.ecode, mon_e.pc);
          end
        end
`ifdef EXC_BADV_EN
        n_checks++;
        if (wb_badv_we !== mon_e.badv_we || (mon_e.badv_we && wb_badv !== mon_e.badv)) begin
          n_fail++;
          $display("FAIL badv: got we=%b badv=%h expected we=%b badv=%h", wb_badv_we, wb_badv,
                   mon_e.badv_we, mon_e.badv);
        end
`endif
      end
    end else if (!reset) begin
      n_checks++;
      if (csr_we || wb_ex || ertn_flush) begin
        n_fail++;
        $display("FAIL stray_strobe: got we/ex/ertn=%b%b%b without commit, expected 000",
                 csr_we, wb_ex, ertn_flush);
      end
    end
  end

  task automatic wait_idle(input string name);
    int k = 0;
    while (wb_ready !== 1'b1 && k < 20) begin
      cyc();
      @(negedge clk);
      k++;
    end
    n_checks++;
    if (wb_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_timeout: wb_ready=%b after %0d cycles, expected 1", name, wb_ready, k);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) cyc();
    reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({wb_ready, redirect_valid, flush_o, csr_we, wb_ex, ertn_flush} !== 6'b100000) begin
      n_fail++;
      $display("FAIL reset_ctrl: got rdy/rv/fl/we/ex/ertn=%b%b%b%b%b%b expected 100000",
               wb_ready, redirect_valid, flush_o, csr_we, wb_ex, ertn_flush);
    end
    n_checks++;
    if (redirect_pc !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_rpc: got %h expected 00000000", redirect_pc);
    end
  endtask

  task automatic test_csrwr();
    cyc();
    wb_valid = 1'b1; wb_exc_vec = '0; wb_is_ertn = 1'b0; wb_csr_op = 2'b01;
    wb_csr_num = 14'h30; wb_rd_val = 32'h12345678; wb_rj_val = $urandom; wb_csr_old = $urandom;
    push_exp(1'b1, 14'h30, 32'h12345678, 1'b0, 6'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    cyc();
    wb_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({wb_ready, redirect_valid, flush_o, csr_we} !== 4'b1000) begin
      n_fail++;
      $display("FAIL csrwr_after: got rdy/rv/fl/we=%b%b%b%b expected 1000", wb_ready,
               redirect_valid, flush_o, csr_we);
    end
  endtask

  task automatic test_csrxchg();
    cyc();
    wb_valid = 1'b1; wb_csr_op = 2'b10; wb_csr_num = 14'h5;
    wb_csr_old = 32'hFFFF0000; wb_rd_val = 32'h00FF00FF; wb_rj_val = 32'h0000FFFF;
    push_exp(1'b1, 14'h5, 32'hFFFF00FF, 1'b0, 6'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    cyc();
    wb_valid = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [1:0] op;
    cyc();
    for (int i = 0; i < 12; i++) begin
      op = 2'(i % 4);
      wb_valid = 1'b1; wb_exc_vec = '0; wb_is_ertn = 1'b0; wb_csr_op = op;
      wb_csr_num = 14'($urandom_range(0, 16383));
      wb_rd_val = $urandom; wb_rj_val = $urandom; wb_csr_old = $urandom;
      push_exp(op == 2'b01 || op == 2'b10, wb_csr_num,
               (op == 2'b01) ? wb_rd_val
                             : (wb_rd_val & wb_rj_val) | (wb_csr_old & ~wb_rj_val),
               1'b0, 6'h0, 32'h0, 1'b0, 1'b0, 32'h0);
      @(negedge clk);
      cyc();
    end
    wb_valid = 1'b0;
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL b2b_drain: %0d expected commits left, expected 0", sb.size());
    end
  endtask

  task automatic test_exception_redirect();
    cyc();
    wb_valid = 1'b1; wb_exc_vec = 6'b101000;  // SYS + ALE
    wb_is_ertn = 1'b0; wb_csr_op = 2'b01; wb_pc_in = 32'h1C0000A4; ex_entry = 32'h1C008000;
    redirect_ready = 1'b0;
    push_exp(1'b0, 14'h0, 32'h0, 1'b1, 6'h0B, 32'h1C0000A4, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    cyc();
    ex_entry = 32'hDEADBEEF;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_checks++;
      if ({redirect_valid, flush_o, wb_ready} !== 3'b110 || redirect_pc !== 32'h1C008000) begin
        n_fail++;
        $display("FAIL redir_hold: cyc %0d got rv/fl/rdy=%b%b%b rpc=%h expected 110 1c008000",
                 i, redirect_valid, flush_o, wb_ready, redirect_pc);
      end
      cyc();
    end
    redirect_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (redirect_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL redir_hs: got rv=%b expected 1", redirect_valid);
    end
    cyc();
    redirect_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if ({redirect_valid, flush_o, wb_ready} !== 3'b010) begin
        n_fail++;
        $display("FAIL drain: cyc %0d got rv/fl/rdy=%b%b%b expected 010", i, redirect_valid,
                 flush_o, wb_ready);
      end
      cyc();
    end
    wb_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({redirect_valid, flush_o, wb_ready} !== 3'b001) begin
      n_fail++;
      $display("FAIL drain_end: got rv/fl/rdy=%b%b%b expected 001", redirect_valid, flush_o,
               wb_ready);
    end
  endtask

  task automatic test_ertn();
    cyc();
    wb_valid = 1'b1; wb_exc_vec = 6'b000001; wb_is_ertn = 1'b1; wb_csr_op = 2'b01;
    wb_pc_in = 32'h1C000200; ex_entry = 32'h1C008800; er_entry = 32'h1C000100;
    push_exp(1'b0, 14'h0, 32'h0, 1'b1, 6'h00, 32'h1C000200, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    cyc();
    wb_valid = 1'b0; redirect_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (redirect_valid !== 1'b1 || redirect_pc !== 32'h1C008800) begin
      n_fail++;
      $display("FAIL ertn_int_rpc: got rv=%b rpc=%h expected 1 1c008800", redirect_valid,
               redirect_pc);
    end
    wait_idle("ertn_int");
    cyc();
    wb_valid = 1'b1; wb_exc_vec = '0; wb_is_ertn = 1'b1;
    push_exp(1'b0, 14'h0, 32'h0, 1'b0, 6'h0, 32'h0, 1'b1, 1'b0, 32'h0);
    @(negedge clk);
    cyc();
    wb_valid = 1'b0; wb_is_ertn = 1'b0;
    @(negedge clk);
    n_checks++;
    if (redirect_valid !== 1'b1 || redirect_pc !== 32'h1C000100) begin
      n_fail++;
      $display("FAIL ertn_rpc: got rv=%b rpc=%h expected 1 1c000100", redirect_valid,
               redirect_pc);
    end
    wait_idle("ertn");
    redirect_ready = 1'b0;
  endtask

  task automatic test_priority();
    logic [5:0]  v;
    logic [5:0]  ec;
    logic [31:0] ent;
    redirect_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      cyc();
      v = (i < 6) ? 6'(1 << i) : 6'($urandom_range(1, 63));
      ec = model_ecode(v);
      ent = $urandom;
      wb_valid = 1'b1; wb_exc_vec = v; wb_is_ertn = 1'(i & 1); wb_csr_op = 2'b10;
      wb_pc_in = $urandom; ex_entry = ent;
`ifdef EXC_BADV_EN
      wb_vaddr = (i == 5) ? 32'h3 : $urandom;
`endif
      push_exp(1'b0, 14'h0, 32'h0, 1'b1, ec, wb_pc_in, 1'b0,
               ec == 6'h08 || ec == 6'h09,
`ifdef EXC_BADV_EN
               (ec == 6'h08) ? wb_pc_in : wb_vaddr);
`else
               32'h0);
`endif
      @(negedge clk);
      cyc();
      wb_valid = 1'b0;
      @(negedge clk);
      n_checks++;
      if (redirect_pc !== ent) begin
        n_fail++;
        $display("FAIL prio_rpc: vec=%b got rpc=%h expected %h", v, redirect_pc, ent);
      end
      wait_idle("prio");
    end
    redirect_ready = 1'b0;
  endtask

  task automatic test_reset_abort();
    // Reset while in REDIR.
    cyc();
    wb_valid = 1'b1; wb_exc_vec = 6'b010000; wb_is_ertn = 1'b0; wb_pc_in = 32'h1C000300;
    ex_entry = 32'h1C00C000; redirect_ready = 1'b0;
    push_exp(1'b0, 14'h0, 32'h0, 1'b1, 6'h0C, 32'h1C000300, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    cyc();
    wb_valid = 1'b0; reset = 1'b1;
    cyc();
    reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({redirect_valid, flush_o, wb_ready} !== 3'b001 || redirect_pc !== 32'h0) begin
      n_fail++;
      $display("FAIL rst_redir: got rv/fl/rdy=%b%b%b rpc=%h expected 001 00000000",
               redirect_valid, flush_o, wb_ready, redirect_pc);
    end
    // Reset in the first DRAIN cycle.
    cyc();
    wb_valid = 1'b1;
    push_exp(1'b0, 14'h0, 32'h0, 1'b1, 6'h0C, 32'h1C000300, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    cyc();
    wb_valid = 1'b0; redirect_ready = 1'b1;
    cyc();
    redirect_ready = 1'b0; reset = 1'b1;
    @(negedge clk);
    n_checks++;
    if (flush_o !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_pre_drain: got flush=%b expected 1", flush_o);
    end
    cyc();
    reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({redirect_valid, flush_o, wb_ready} !== 3'b001) begin
      n_fail++;
      $display("FAIL rst_drain: got rv/fl/rdy=%b%b%b expected 001", redirect_valid, flush_o,
               wb_ready);
    end
  endtask

  initial begin
    test_reset();
    test_csrwr();
    test_csrxchg();
    test_back_to_back();
    test_exception_redirect();
    test_ertn();
    test_priority();
    test_reset_abort();
    cyc();
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL sb_leftover: %0d expected commits never seen, expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
